// File: rtl/vend_txn_controller_if.sv
// rtl/vend_txn_controller_if.sv - coin/keypad front end and dispense/hopper actuator bundle
interface vend_txn_controller_if;
  logic       coin_valid;
  logic [4:0] coin_value;
  logic       sel_valid;
  logic [5:0] sel_item;
  logic       cancel;
  logic       coin_reject;
  logic       err_item;
  logic       err_funds;
  logic       timeout;
  logic       vend_req;
  logic [5:0] vend_item;
  logic       vend_done;
  logic       payout_req;
  logic [4:0] payout_coin;
  logic       payout_ack;
  logic [4:0] credit;
  logic       busy;

  modport master (
    output coin_valid, coin_value, sel_valid, sel_item, cancel, vend_done, payout_ack,
    input  coin_reject, err_item, err_funds, timeout, vend_req, vend_item,
           payout_req, payout_coin, credit, busy
  );

  modport slave (
    input  coin_valid, coin_value, sel_valid, sel_item, cancel, vend_done, payout_ack,
    output coin_reject, err_item, err_funds, timeout, vend_req, vend_item,
           payout_req, payout_coin, credit, busy
  );
endinterface

// File: rtl/vend_txn_controller.sv
// rtl/vend_txn_controller.sv - vending transaction sequencer: credit, selection, vend and change payout
module vend_txn_controller #(
  parameter int CLK_PER_SEC  = 100,
  parameter int TIMEOUT_SEC  = 20,
  parameter int PRICE_NEWS   = 5,
  parameter int PRICE_COFFEE = 10,
  parameter int PRICE_LAYS   = 15,
  parameter int MAX_CREDIT   = 31
) (
  input  logic clk,
  input  logic reset,
  vend_txn_controller_if.slave bus
);
  localparam int TIMEOUT_CYCLES = CLK_PER_SEC * TIMEOUT_SEC;
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, PAYOUT} state_t;

  state_t           state;
  logic [CNT_W-1:0] idle_cnt;
  logic [4:0]       credit_q;
  logic             coin_reject_q, err_item_q, err_funds_q, timeout_q;
  logic             vend_req_q, payout_req_q, busy_q;
  logic [5:0]       vend_item_q;
  logic [4:0]       payout_coin_q;

  logic [5:0] coin_sum;
  logic       coin_ok;
  logic [4:0] price;
  logic [4:0] big_coin;
  logic       cancel_take;

  assign coin_sum = {1'b0, credit_q} + {1'b0, bus.coin_value};
  assign coin_ok  = (bus.coin_value == 5'd1 || bus.coin_value == 5'd5 || bus.coin_value == 5'd10)
                    && (coin_sum <= 6'(MAX_CREDIT));
  // Largest hopper denomination that still fits in the remaining credit.
  assign big_coin    = (credit_q >= 5'd10) ? 5'd10 : ((credit_q >= 5'd5) ? 5'd5 : 5'd1);
  assign cancel_take = bus.cancel && (state == CREDIT) && (credit_q != 5'd0);

  always_comb begin
    price = 5'd0;
    case (bus.sel_item)
      6'd1:    price = 5'(PRICE_NEWS);
      6'd2:    price = 5'(PRICE_COFFEE);
      6'd3:    price = 5'(PRICE_LAYS);
      default: price = 5'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      idle_cnt      <= '0;
      credit_q      <= 5'd0;
      coin_reject_q <= 1'b0;
      err_item_q    <= 1'b0;
      err_funds_q   <= 1'b0;
      timeout_q     <= 1'b0;
      vend_req_q    <= 1'b0;
      vend_item_q   <= 6'd0;
      payout_req_q  <= 1'b0;
      payout_coin_q <= 5'd0;
      busy_q        <= 1'b0;
    end else begin
      coin_reject_q <= 1'b0;
      err_item_q    <= 1'b0;
      err_funds_q   <= 1'b0;
      timeout_q     <= 1'b0;
      case (state)
        IDLE, CREDIT: begin
          if (cancel_take) begin
            coin_reject_q <= bus.coin_valid;
            state         <= PAYOUT;
            payout_req_q  <= 1'b1;
            payout_coin_q <= big_coin;
            busy_q        <= 1'b1;
            idle_cnt      <= '0;
          end else if (bus.sel_valid) begin
            // A coin arriving with a selection is returned; price is checked on pre-coin credit.
            coin_reject_q <= bus.coin_valid;
            idle_cnt      <= '0;
            if (price == 5'd0) begin
              err_item_q <= 1'b1;
            end else if (credit_q < price) begin
              err_funds_q <= 1'b1;
            end else begin
              credit_q    <= credit_q - price;
              vend_req_q  <= 1'b1;
              vend_item_q <= bus.sel_item;
              state       <= VEND;
              busy_q      <= 1'b1;
            end
          end else if (bus.coin_valid && coin_ok) begin
            credit_q <= coin_sum[4:0];
            state    <= CREDIT;
            idle_cnt <= '0;
          end else begin
            coin_reject_q <= bus.coin_valid;
            if (state == CREDIT) begin
              if (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                timeout_q     <= 1'b1;
                state         <= PAYOUT;
                payout_req_q  <= 1'b1;
                payout_coin_q <= big_coin;
                busy_q        <= 1'b1;
                idle_cnt      <= '0;
              end else begin
                idle_cnt <= idle_cnt + 1'b1;
              end
            end
          end
        end
        VEND: begin
          coin_reject_q <= bus.coin_valid;
          if (vend_req_q && bus.vend_done) begin
            vend_req_q <= 1'b0;
            if (credit_q != 5'd0) begin
              state         <= PAYOUT;
              payout_req_q  <= 1'b1;
              payout_coin_q <= big_coin;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        PAYOUT: begin
          coin_reject_q <= bus.coin_valid;
          if (payout_req_q) begin
            if (bus.payout_ack) begin
              credit_q     <= credit_q - payout_coin_q;
              payout_req_q <= 1'b0;
              if (credit_q == payout_coin_q) begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end
            end
          end else begin
            payout_req_q  <= 1'b1;
            payout_coin_q <= big_coin;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.coin_reject = coin_reject_q;
  assign bus.err_item    = err_item_q;
  assign bus.err_funds   = err_funds_q;
  assign bus.timeout     = timeout_q;
  assign bus.vend_req    = vend_req_q;
  assign bus.vend_item   = vend_item_q;
  assign bus.payout_req  = payout_req_q;
  assign bus.payout_coin = payout_coin_q;
  assign bus.credit      = credit_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_vend_txn_controller.sv
// tb/tb_vend_txn_controller.sv - randomized and directed checks of vend_txn_controller against a transaction model
module tb_vend_txn_controller;
  localparam int TMO = 2000;
  localparam int P_IDLE = 0, P_CREDIT = 1, P_VEND = 2, P_PAY = 3;

  logic clk;
  logic reset;
  vend_txn_controller_if bus();

  vend_txn_controller dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 0;
  int paid[$];

  int m_credit, m_phase, m_cnt, m_vitem, m_pcoin;
  bit m_vreq, m_preq, m_rej, m_eitem, m_efunds, m_tmo;

  task automatic cmp(input string name, input logic [31:0] act, input int exp);
    n_assert++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int biggest(input int c);
    return (c >= 10) ? 10 : ((c >= 5) ? 5 : 1);
  endfunction

  function automatic int price_of(input int it);
    case (it)
      1: return 5;
      2: return 10;
      3: return 15;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_credit = 0; m_phase = P_IDLE; m_cnt = 0; m_vitem = 0; m_pcoin = 0;
    m_vreq = 0; m_preq = 0; m_rej = 0; m_eitem = 0; m_efunds = 0; m_tmo = 0;
  endtask

  task automatic start_payout();
    m_phase = P_PAY; m_preq = 1; m_pcoin = biggest(m_credit); m_cnt = 0;
  endtask

  // One clock of the transaction rules, applied to the inputs present at the edge.
  task automatic model_step();
    int p;
    int cv;
    cv = int'(bus.coin_value);
    m_rej = 0; m_eitem = 0; m_efunds = 0; m_tmo = 0;
    if (m_phase == P_IDLE || m_phase == P_CREDIT) begin
      if (bus.cancel && m_phase == P_CREDIT && m_credit > 0) begin
        m_rej = bus.coin_valid;
        start_payout();
      end else if (bus.sel_valid) begin
        m_rej = bus.coin_valid;
        m_cnt = 0;
        p = price_of(int'(bus.sel_item));
        if (p == 0) m_eitem = 1;
        else if (m_credit < p) m_efunds = 1;
        else begin
          m_credit -= p; m_phase = P_VEND; m_vreq = 1; m_vitem = int'(bus.sel_item);
        end
      end else if (bus.coin_valid && (cv inside {1, 5, 10}) && m_credit + cv <= 31) begin
        m_credit += cv; m_phase = P_CREDIT; m_cnt = 0;
      end else begin
        m_rej = bus.coin_valid;
        if (m_phase == P_CREDIT) begin
          m_cnt++;
          if (m_cnt == TMO) begin
            m_tmo = 1;
            start_payout();
          end
        end
      end
    end else if (m_phase == P_VEND) begin
      m_rej = bus.coin_valid;
      if (m_vreq && bus.vend_done) begin
        m_vreq = 0;
        if (m_credit > 0) start_payout();
        else m_phase = P_IDLE;
      end
    end else begin
      m_rej = bus.coin_valid;
      if (m_preq) begin
        if (bus.payout_ack) begin
          m_credit -= m_pcoin; m_preq = 0;
          if (m_credit == 0) m_phase = P_IDLE;
        end
      end else begin
        m_preq = 1; m_pcoin = biggest(m_credit);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        cmp("credit", bus.credit, m_credit);
        cmp("busy", bus.busy, int'(m_phase == P_VEND || m_phase == P_PAY));
        cmp("coin_reject", bus.coin_reject, m_rej);
        cmp("err_item", bus.err_item, m_eitem);
        cmp("err_funds", bus.err_funds, m_efunds);
        cmp("timeout", bus.timeout, m_tmo);
        cmp("vend_req", bus.vend_req, m_vreq);
        cmp("payout_req", bus.payout_req, m_preq);
        if (m_vreq) cmp("vend_item", bus.vend_item, m_vitem);
        if (m_preq) cmp("payout_coin", bus.payout_coin, m_pcoin);
        if (bus.payout_req && bus.payout_ack) paid.push_back(int'(bus.payout_coin));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    else model_reset();
    #1;
  endtask

  task automatic coin(input int v);
    bus.coin_valid = 1'b1; bus.coin_value = 5'(v);
    tick();
    bus.coin_valid = 1'b0;
  endtask

  task automatic sel(input int it);
    bus.sel_valid = 1'b1; bus.sel_item = 6'(it);
    tick();
    bus.sel_valid = 1'b0;
  endtask

  task automatic serve();
    int n;
    n = 0;
    while ((m_phase == P_VEND || m_phase == P_PAY) && n < 300) begin
      bus.vend_done  = m_vreq && ($urandom_range(0, 2) == 0);
      bus.payout_ack = m_preq && ($urandom_range(0, 2) == 0);
      tick();
      n++;
    end
    bus.vend_done = 1'b0; bus.payout_ack = 1'b0;
    cmp("serve_idle", bus.busy, 0);
  endtask

  task automatic chk_paid(input string name, input int e[$]);
    cmp({name, "_count"}, paid.size(), e.size());
    foreach (e[i]) if (i < paid.size()) cmp({name, "_coin"}, paid[i], e[i]);
    paid.delete();
  endtask

  initial begin
    int vals[6];
    int e[$];
    vals = '{1, 5, 10, 7, 0, 31};
    reset = 1'b0;
    bus.coin_valid = 0; bus.coin_value = 0; bus.sel_valid = 0; bus.sel_item = 0;
    bus.cancel = 0; bus.vend_done = 0; bus.payout_ack = 0;
    model_reset();
    repeat (3) @(negedge clk);
    cmp("rst_credit", bus.credit, 0);
    cmp("rst_busy", bus.busy, 0);
    cmp("rst_vend_req", bus.vend_req, 0);
    cmp("rst_payout_req", bus.payout_req, 0);
    cmp("rst_pulses", {bus.coin_reject, bus.err_item, bus.err_funds, bus.timeout}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    chk_en = 1;

    // Reset while paying out 15
    coin(10); coin(5);
    bus.cancel = 1'b1; tick(); bus.cancel = 1'b0;
    cmp("pay15_credit", bus.credit, 15);
    cmp("pay15_coin", bus.payout_coin, 10);
    reset = 1'b0; model_reset();
    @(negedge clk); #1;
    cmp("midrst_credit", bus.credit, 0);
    cmp("midrst_payout_req", bus.payout_req, 0);
    cmp("midrst_busy", bus.busy, 0);
    tick();
    reset = 1'b1;
    paid.delete();

    // Exact-price vend, no change
    coin(5); coin(10); sel(3);
    cmp("lays_vend_req", bus.vend_req, 1);
    cmp("lays_vend_item", bus.vend_item, 3);
    cmp("lays_credit", bus.credit, 0);
    serve();
    e = {}; chk_paid("lays_change", e);

    // Change of 16 returned as 10, 5, 1
    coin(10); coin(10); coin(1); sel(1);
    cmp("news_credit", bus.credit, 16);
    serve();
    e = {10, 5, 1}; chk_paid("news_change", e);
    cmp("news_final_credit", bus.credit, 0);

    // Error pulses
    coin(5); sel(2);
    cmp("err_funds_pulse", bus.err_funds, 1);
    sel(9);
    cmp("err_item_pulse", bus.err_item, 1);
    coin(7);
    cmp("bad_coin_reject", bus.coin_reject, 1);
    cmp("bad_coin_credit", bus.credit, 5);
    bus.cancel = 1'b1; tick(); bus.cancel = 1'b0;
    serve();
    e = {5}; chk_paid("cancel5", e);

    // Overflow reject, then simultaneous selection and coin
    coin(10); coin(10); coin(10); coin(5);
    cmp("ovf_reject", bus.coin_reject, 1);
    cmp("ovf_credit", bus.credit, 30);
    bus.sel_valid = 1'b1; bus.sel_item = 6'd3; bus.coin_valid = 1'b1; bus.coin_value = 5'd1;
    tick();
    bus.sel_valid = 1'b0; bus.coin_valid = 1'b0;
    cmp("combo_reject", bus.coin_reject, 1);
    cmp("combo_vend_req", bus.vend_req, 1);
    cmp("combo_credit", bus.credit, 15);
    serve();
    e = {10, 5}; chk_paid("combo_change", e);

    // Inactivity timeout
    coin(10);
    repeat (TMO - 1) tick();
    cmp("pre_timeout", bus.timeout, 0);
    tick();
    cmp("timeout_pulse", bus.timeout, 1);
    cmp("timeout_coin", bus.payout_coin, 10);
    coin(5);
    cmp("payout_coin_reject", bus.coin_reject, 1);
    serve();
    e = {10}; chk_paid("timeout_refund", e);
    coin(5); coin(1);
    bus.cancel = 1'b1; tick(); bus.cancel = 1'b0;
    serve();
    e = {5, 1}; chk_paid("cancel6", e);

    // Randomized traffic
    repeat (4000) begin
      bus.cancel     = ($urandom_range(0, 39) == 0);
      bus.sel_valid  = ($urandom_range(0, 14) == 0);
      bus.sel_item   = 6'($urandom_range(0, 5));
      bus.coin_valid = ($urandom_range(0, 3) == 0);
      bus.coin_value = 5'(vals[$urandom_range(0, 5)]);
      bus.vend_done  = m_vreq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      bus.payout_ack = m_preq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      tick();
    end
    bus.cancel = 0; bus.sel_valid = 0; bus.coin_valid = 0;
    serve();
    paid.delete();

    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/vend_txn_controller.md
Name: vend_txn_controller

Overview:
- Transaction sequencer for the vending machine.
- Accumulates coin credit and validates item selections against a price list.
- Drives the dispense-motor handshake, then returns change through the coin-hopper handshake using the largest coins first.
- Sits between the coin acceptor/keypad front end and the dispense/hopper actuators, with refunds on cancel and on inactivity timeout.

Parameters:
- CLK_PER_SEC, 100, clock cycles per second (timeout base)
- TIMEOUT_SEC, 20, idle seconds in CREDIT before automatic refund
- PRICE_NEWS, 5, price of item 1 (newspaper)
- PRICE_COFFEE, 10, price of item 2 (coffee)
- PRICE_LAYS, 15, price of item 3 (lays)
- MAX_CREDIT, 31, credit ceiling; must fit 5 bits

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- coin_valid  in  1  one-cycle pulse; coin_value is valid
- coin_value  in  5  inserted coin denomination
- sel_valid  in  1  one-cycle pulse; sel_item is valid
- sel_item  in  6  requested item code
- cancel  in  1  level; request refund
- coin_reject  out  1  one-cycle pulse; coin not credited, returned mechanically
- err_item  out  1  one-cycle pulse; unknown item code
- err_funds  out  1  one-cycle pulse; credit below price
- timeout  out  1  one-cycle pulse; inactivity refund started
- vend_req  out  1  dispense request, held until vend_done
- vend_item  out  6  item being dispensed, stable while vend_req=1
- vend_done  in  1  motor completion pulse
- payout_req  out  1  hopper request, held until payout_ack
- payout_coin  out  5  denomination to pay (10, 5 or 1)
- payout_ack  in  1  hopper completion pulse
- credit  out  5  current credit
- busy  out  1  high in VEND or PAYOUT

Behaviour:
- Reset (reset=0, asynchronous) puts the block in IDLE. All outputs are 0, credit=0, the timeout counter is 0, and any in-flight handshake is abandoned.
- All outputs are registered; every response appears the cycle after the triggering input.
- States are IDLE, CREDIT, VEND and PAYOUT.
- Valid coins are 1, 5 and 10.
  - A coin is accepted only in IDLE or CREDIT, and only when credit+coin_value <= MAX_CREDIT.
  - On acceptance, credit += coin_value and the state becomes CREDIT.
  - Any other coin (invalid value, overflow, or arriving in VEND/PAYOUT) pulses coin_reject; credit is unchanged.
- Priority in IDLE/CREDIT within one cycle: cancel > sel_valid > coin_valid.
  - If sel_valid and coin_valid arrive together, the coin is rejected and the selection is evaluated against the pre-coin credit.
- Selection in IDLE/CREDIT:
  - Item codes 1, 2, 3 map to PRICE_NEWS, PRICE_COFFEE, PRICE_LAYS. Any other code pulses err_item; state unchanged.
  - If credit < price, err_funds pulses; state unchanged.
  - Otherwise go to VEND: vend_req=1, vend_item=sel_item, credit -= price (applied on entry).
- VEND:
  - vend_done is sampled only while vend_req=1; vend_req drops the cycle after vend_done is seen.
  - Then go to PAYOUT if credit>0, else IDLE.
  - There is no timeout in VEND.
- Cancel:
  - In CREDIT with credit>0, cancel goes to PAYOUT (full refund).
  - In IDLE, cancel is ignored.
  - In VEND/PAYOUT, cancel is ignored and the transaction completes.
- Inactivity timeout:
  - The counter runs only in CREDIT and clears on any accepted coin or any sel_valid.
  - At TIMEOUT_SEC*CLK_PER_SEC cycles, timeout pulses and the block goes to PAYOUT.
- PAYOUT:
  - payout_coin is the largest of {10,5,1} that is <= credit. payout_req is held until payout_ack.
  - On ack, credit -= payout_coin and payout_req drops for one cycle. The next coin is requested the following cycle.
  - When credit reaches 0, go to IDLE.
  - payout_ack while payout_req=0 is ignored.
- busy=1 in VEND and PAYOUT.
- Credit never wraps: additions are guarded by the MAX_CREDIT check, and subtractions never underflow by construction.
- Handshake inputs (vend_done, payout_ack) are ignored in all other states.

Test Plan:
- Reset low mid-PAYOUT with credit=15 → next cycle: state IDLE, credit=0, payout_req=0, all pulses 0.
- Coins 5,10 then sel_item=3 → vend_req=1, vend_item=3, credit=0. vend_done → vend_req=0, back to IDLE with no payout.
- Coins 10,10,1 (credit=21) then sel_item=1 → vend, credit=16. After vend_done, payouts are 10, 5, 1 with one ack each, then IDLE, credit=0.
- Credit=5, sel_item=2 → err_funds pulse, credit=5. Then sel_item=9 → err_item pulse. Then coin_value=7 → coin_reject, credit=5.
- Credit=30, coin 5 → coin_reject. Same cycle sel_valid=1 for item 3 and coin_valid=1 for coin 1 → coin_reject, vend item 3, credit=15.
- Credit=10, no activity for 2000 cycles (default parameters) → timeout pulse, one payout of 10. A coin during PAYOUT → coin_reject. Cancel with credit=6 → payouts 5, 1.
